and_operand_sequencer: RTL and testbench
========================================

// Module: and_operand_sequencer
//
// PURPOSE
//   Upstream operand stage for the 8-bit AND unit. It takes one shared byte
//   stream in which operands arrive in A-then-B order. It pairs each A with
//   the B that follows it and buffers complete pairs in a small FIFO. It
//   presents the head pair as a/b operands with a valid/ready handshake.
//   The AND stage's a/b inputs are fed from a_out/b_out.
//
// PARAMETERS
//   WIDTH  8  operand width in bits
//   DEPTH  2  number of pair FIFO entries; must be a power of 2 and >= 2
//
// PORTS
//   clk        in   1              single clock; all state updates on its rising edge
//   reset      in   1              synchronous reset, active-high
//   in_data    in   WIDTH          operand byte; A when phase=0, B when phase=1
//   in_valid   in   1              in_data is valid
//   in_ready   out  1              sequencer accepts in_data this cycle
//   in_clear   in   1              discard a held A (abort the partial pair)
//   a_out      out  WIDTH          head pair, operand A
//   b_out      out  WIDTH          head pair, operand B
//   out_valid  out  1              a head pair is present
//   out_ready  in   1              consumer takes the head pair this cycle
//   count      out  $clog2(DEPTH+1) number of complete pairs stored
//   phase      out  1              0 = waiting for A, 1 = holding A and waiting for B
//
// BEHAVIOUR
//   - Reset (sync, active-high):
//     - state S_A, phase=0, FIFO empty, count=0, A-hold register cleared.
//     - out_valid=0, a_out=b_out=0.
//     - in_ready is forced to 0 while reset=1.
//   - Input accept: a transfer occurs when in_valid && in_ready.
//   - FSM:
//     - S_A: in_ready=1 (the A-hold register is always free). On accept,
//       a_hold<=in_data and go to S_B.
//     - S_B: in_ready = !full || (out_valid && out_ready).
//       On accept, push {a_hold, in_data} and go to S_A.
//     - in_clear=1 in S_B: go to S_A, drop a_hold, force in_ready=0 that
//       cycle. FIFO contents are untouched.
//     - in_clear=1 in S_A: no effect. in_ready is still forced to 0 that cycle.
//   - Output:
//     - out_valid = !empty.
//     - a_out/b_out = head entry when out_valid=1, otherwise 0.
//     - Pop on out_valid && out_ready.
//     - a_out/b_out are stable while out_valid && !out_ready.
//   - Latency: a pair is visible on out_valid the cycle after its B is
//     accepted. There is no bypass, including when the FIFO is empty.
//   - Simultaneous push and pop:
//     - Allowed when full or partly full; count is unchanged.
//     - When empty, only the push occurs (out_valid was 0, so no pop).
//   - Pointers: rd/wr pointers wrap modulo DEPTH. Full/empty come from count.
//   - Order: pairs leave in arrival order. A values are never reordered or
//     mixed across pairs.
//   - in_ready depends combinationally on out_ready (full case only). The
//     consumer must not derive out_ready from in_ready.
//   - Reset mid-operation: all stored pairs and any held A are lost. There is
//     no partial output.
//
// TESTING
//   1. Basic pair: reset, out_ready=1, send 0xF0 then 0x3C
//      -> next cycle out_valid=1, a_out=F0, b_out=3C; popped; count back to 0.
//   2. Backpressure (DEPTH=2): out_ready=0, send 3 pairs
//      -> count=2; third A accepted (phase=1); in_ready=0 on third B.
//   3. Full with simultaneous push/pop: FIFO full, raise out_ready while the
//      third B is valid -> B accepted; pair 1 popped; count stays 2; order 1,2,3.
//   4. Clear: send A=0xAA, pulse in_clear, then send 0x55, 0x0F
//      -> only pair (55,0F) emerges; 0xAA never appears; phase=0 after the clear.
//   5. Reset mid-op: 1 pair stored and phase=1, assert reset for 1 cycle
//      -> out_valid=0, count=0, phase=0, a_out=b_out=0.
//   6. Wrap/soak: 20 random pairs with random in_valid/out_ready and the
//      scoreboard checking a_out&b_out order -> all match, pointers wrap
//      correctly, no drops.

Source files
------------

// File: rtl/and_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | and_operand_sequencer: pairs an A-then-B byte stream into a small FIFO   |
// | and presents the head pair to the AND unit over valid/ready.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module and_operand_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_clear,
  output logic [WIDTH-1:0]           a_out,
  output logic [WIDTH-1:0]           b_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       phase
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_A = 1'b0,
    S_B = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_hold_q, a_hold_d;
  logic [2*WIDTH-1:0]     mem_q [DEPTH];
  logic [2*WIDTH-1:0]     mem_d [DEPTH];
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   accept;
  logic [2*WIDTH-1:0]     head;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    head      = mem_q[rd_ptr_q];
    a_out     = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
    b_out     = out_valid ? head[WIDTH-1:0]       : '0;
    count     = count_q;
    phase     = (state_q == S_B);

    // A full FIFO can still take the B when the head leaves this same cycle.
    in_ready = 1'b0;
    if (!reset && !in_clear) begin
      in_ready = (state_q == S_A) ? 1'b1 : (!full || pop);
    end

    accept = in_valid && in_ready;
    push   = accept && (state_q == S_B);

    state_d  = state_q;
    a_hold_d = a_hold_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (in_clear) begin
      state_d  = S_A;
      a_hold_d = '0;
    end else if (accept) begin
      if (state_q == S_A) begin
        a_hold_d = in_data;
        state_d  = S_B;
      end else begin
        state_d  = S_A;
        a_hold_d = '0;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = {a_hold_q, in_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_A;
      a_hold_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      a_hold_q <= a_hold_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_and_operand_sequencer: directed and random stimulus against a queue  |
// | model of the pair stream.                                               |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_and_operand_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_clear;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;
  logic             phase;

  and_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_clear  (in_clear),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of complete {A,B} pairs plus an optional held A.
  logic [15:0] pairs [$];
  logic        have_a = 1'b0;
  logic [7:0]  held   = 8'h00;
  int          popped = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs with the model, then advance.
  task automatic step(input logic v, input logic [7:0] d, input logic clr, input logic ordy);
    logic        exp_rdy;
    logic        do_pop;
    logic        do_acc;
    logic [15:0] hd;
    in_valid  = v;
    in_data   = d;
    in_clear  = clr;
    out_ready = ordy;
    #1;
    if (clr)          exp_rdy = 1'b0;
    else if (!have_a) exp_rdy = 1'b1;
    else              exp_rdy = (pairs.size() < DEPTH) || (pairs.size() > 0 && ordy);
    hd = (pairs.size() > 0) ? pairs[0] : 16'h0000;
    chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, (pairs.size() > 0) ? 32'd1 : 32'd0);
    chk("a_out",     {24'd0, a_out},     {24'd0, hd[15:8]});
    chk("b_out",     {24'd0, b_out},     {24'd0, hd[7:0]});
    chk("count",     {30'd0, count},     pairs.size());
    chk("phase",     {31'd0, phase},     {31'd0, have_a});
    do_pop = (pairs.size() > 0) && ordy;
    do_acc = v && exp_rdy;
    @(posedge clk);
    if (do_pop) begin
      void'(pairs.pop_front());
      popped++;
    end
    if (clr) begin
      have_a = 1'b0;
    end else if (do_acc) begin
      if (!have_a) begin
        held   = d;
        have_a = 1'b1;
      end else begin
        pairs.push_back({held, d});
        have_a = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    pairs.delete();
    have_a = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count",     {30'd0, count},     32'd0);
    chk("rst_phase",     {31'd0, phase},     32'd0);
    chk("rst_a_out",     {24'd0, a_out},     32'd0);
    chk("rst_b_out",     {24'd0, b_out},     32'd0);
    @(negedge clk);
  endtask

  initial begin
    int cyc;

    // Basic pair
    do_reset();
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_a",     {24'd0, a_out},     32'hF0);
    chk("t1_b",     {24'd0, b_out},     32'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t1_count", {30'd0, count}, 32'd0);

    // Backpressure: fill, hold a third A, B refused while full
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2_count", {30'd0, count}, 32'd2);
    chk("t2_phase", {31'd0, phase}, 32'd1);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    chk("t2_still_full", {30'd0, count}, 32'd2);

    // Full with simultaneous push/pop, then drain in order
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("t3_count", {30'd0, count}, 32'd2);
    chk("t3_head_a", {24'd0, a_out}, 32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_head2_a", {24'd0, a_out}, 32'h55);
    chk("t3_head2_b", {24'd0, b_out}, 32'h66);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Clear drops the held A
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_phase", {31'd0, phase}, 32'd0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    chk("t4_a", {24'd0, a_out}, 32'h55);
    chk("t4_b", {24'd0, b_out}, 32'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    chk("t5_pre_phase", {31'd0, phase}, 32'd1);
    do_reset();

    // Random soak until 20 pairs have left the FIFO
    popped = 0;
    cyc    = 0;
    while (popped < 20 && cyc < 2000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("soak_pairs_out", (popped >= 20) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
